// File: rtl/pc_sequencer_if.sv
// Fetch/control handshake between the pc sequencer (master) and the ROM/datapath (slave).
interface pc_sequencer_if;
    logic       start;
    logic       stall;
    logic [9:0] instr;
    logic       eq_flag;
    logic [9:0] pc;
    logic       exec_en;
    logic       halted;
    logic       stk_err;
    logic [2:0] sp;

    modport master (
        input  start, stall, instr, eq_flag,
        output pc, exec_en, halted, stk_err, sp
    );

    modport slave (
        output start, stall, instr, eq_flag,
        input  pc, exec_en, halted, stk_err, sp
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter, control-flow decode and return-address stack for the 10-bit computer.
// Zero-bubble fetch (next pc one cycle after commit); stall freezes all state and drops exec_en.
module pc_sequencer #(
    parameter logic [9:0] RESET_PC    = 10'd0,
    parameter int         STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus
);
    localparam int         IDXW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] DEPTH = 4'(STACK_DEPTH);

    localparam logic [3:0] OP_J    = 4'b1100;
    localparam logic [3:0] OP_JE   = 4'b1101;
    localparam logic [3:0] OP_JAL  = 4'b1110;
    localparam logic [3:0] OP_RET  = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t     state;
    logic [9:0] pc_q;
    logic [3:0] cnt;
    logic       stk_err_q;
    logic [9:0] stack [2**IDXW];

    logic [3:0]      op;
    logic [9:0]      off;
    logic [9:0]      target;
    logic [9:0]      inc;
    logic [9:0]      top;
    logic [IDXW-1:0] top_idx;
    logic [IDXW-1:0] push_idx;
    logic            full;
    logic            empty;
    logic            go;
    logic            err;
    logic            push;

    always_comb begin
        op       = bus.instr[9:6];
        off      = {{4{bus.instr[5]}}, bus.instr[5:0]};
        target   = pc_q + off;
        inc      = pc_q + 10'd1;
        full     = (cnt == DEPTH);
        empty    = (cnt == 4'd0);
        top_idx  = IDXW'(cnt - 4'd1);
        push_idx = IDXW'(cnt);
        top      = stack[top_idx];
        go       = (state == RUN) && !bus.stall;
        err      = ((op == OP_JAL) && full) || ((op == OP_RET) && empty);
        push     = go && (op == OP_JAL) && !full;
    end

    // Stack contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            cnt       <= 4'd0;
            stk_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        pc_q  <= RESET_PC;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        case (op)
                            OP_J:  pc_q <= target;
                            OP_JE: pc_q <= bus.eq_flag ? target : inc;
                            OP_JAL: begin
                                if (full) begin
                                    stk_err_q <= 1'b1;
                                    state     <= HALT;
                                end else begin
                                    cnt  <= cnt + 4'd1;
                                    pc_q <= target;
                                end
                            end
                            OP_RET: begin
                                if (empty) begin
                                    stk_err_q <= 1'b1;
                                    state     <= HALT;
                                end else begin
                                    cnt  <= cnt - 4'd1;
                                    pc_q <= top;
                                end
                            end
                            OP_HALT: state <= HALT;
                            default: pc_q  <= inc;
                        endcase
                    end
                end
                HALT: begin
                    if (bus.start) begin
                        state <= RUN;
                        pc_q  <= RESET_PC;
                        cnt   <= 4'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A faulting jal/ret is not committed; a halt instruction is.
    assign bus.exec_en = go && !err;
    assign bus.pc      = pc_q;
    assign bus.halted  = (state == HALT);
    assign bus.stk_err = stk_err_q;
    assign bus.sp      = cnt[2:0];
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed checks of pc_sequencer against a queue-based behavioural model.
module tb_pc_sequencer;
    localparam int DEPTH = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if bus();
    pc_sequencer #(.RESET_PC(10'd0), .STACK_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [9:0] rom [1024];
    assign bus.instr = rom[bus.pc];

    int vectors = 0;
    int miscompares = 0;

    int m_mode = M_IDLE;
    int m_pc = 0;
    int m_stk[$];
    bit m_err = 1'b0;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [9:0] filler();
        logic [3:0] op;
        do op = 4'($urandom_range(0, 15));
        while (op inside {4'b1100, 4'b1101, 4'b1110, 4'b0111, 4'b1111});
        return {op, 6'($urandom_range(0, 63))};
    endfunction

    function automatic int sext6(logic [5:0] f);
        return (f >= 6'd32) ? int'(f) - 64 : int'(f);
    endfunction

    function automatic bit m_fault();
        logic [9:0] w;
        w = rom[m_pc];
        return (w[9:6] == 4'b1110 && m_stk.size() == DEPTH) || (w[9:6] == 4'b0111 && m_stk.size() == 0);
    endfunction

    function automatic logic [15:0] mdl_obs();
        logic ex, h;
        ex = (m_mode == M_RUN) && !bus.stall && !m_fault();
        h  = (m_mode == M_HALT);
        return {10'(m_pc), ex, h, m_err, 3'(m_stk.size())};
    endfunction

    function automatic logic [15:0] dut_obs();
        return {bus.pc, bus.exec_en, bus.halted, bus.stk_err, bus.sp};
    endfunction

    task automatic m_step();
        logic [9:0] w;
        int tgt, seq;
        if (rst) begin
            m_mode = M_IDLE; m_pc = 0; m_stk.delete(); m_err = 1'b0;
        end else if (m_mode == M_IDLE) begin
            if (bus.start) begin m_mode = M_RUN; m_pc = 0; end
        end else if (m_mode == M_HALT) begin
            if (bus.start) begin m_mode = M_RUN; m_pc = 0; m_stk.delete(); end
        end else if (!bus.stall) begin
            w   = rom[m_pc];
            tgt = (m_pc + sext6(w[5:0]) + 1024) % 1024;
            seq = (m_pc + 1) % 1024;
            case (w[9:6])
                4'b1100: m_pc = tgt;
                4'b1101: m_pc = bus.eq_flag ? tgt : seq;
                4'b1110: if (m_stk.size() == DEPTH) begin m_err = 1'b1; m_mode = M_HALT; end
                         else begin m_stk.push_back(seq); m_pc = tgt; end
                4'b0111: if (m_stk.size() == 0) begin m_err = 1'b1; m_mode = M_HALT; end
                         else m_pc = m_stk.pop_back();
                4'b1111: m_mode = M_HALT;
                default: m_pc = seq;
            endcase
        end
    endtask

    task automatic set_in(input bit s, input bit st, input bit eq);
        bus.start = s; bus.stall = st; bus.eq_flag = eq;
        #1;
    endtask

    task automatic clk_step();
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        rst = 1'b1; set_in(0, 0, 0); clk_step();
        rst = 1'b0; set_in(1, 0, 0); clk_step();
        set_in(0, 0, 0);
    endtask

    task automatic fill_rom();
        for (int a = 0; a < 1024; a++) rom[a] = filler();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin set_in(rb(), rb(), rb()); clk_step(); end
        set_in(0, 0, 0);
        vectors++;
        if (dut_obs() !== 16'h0000) begin miscompares++; $display("FAIL reset_state got=%h want=0000", dut_obs()); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(0, rb(), rb()); vectors++;
            if (dut_obs() !== mdl_obs()) begin miscompares++; $display("FAIL idle_hold got=%h want=%h", dut_obs(), mdl_obs()); end
            clk_step();
        end
    endtask

    task automatic test_straight();
        fill_rom(); rom[35] = 10'b1111_000000;
        set_in(1, 0, 0); clk_step();
        for (int c = 0; c < 40; c++) begin
            set_in(0, 0, rb()); vectors++;
            if (dut_obs() !== mdl_obs()) begin miscompares++; $display("FAIL straight c=%0d got=%h want=%h", c, dut_obs(), mdl_obs()); end
            clk_step();
        end
        vectors++;
        if (bus.pc !== 10'd35 || bus.halted !== 1'b1) begin miscompares++; $display("FAIL halt_at_35 pc=%0d halted=%b want 35/1", bus.pc, bus.halted); end
    endtask

    task automatic test_branches();
        fill_rom(); rom[6] = 10'b1101011010; rom[34] = 10'b1111_000000; rom[45] = 10'b1100110111;
        set_in(1, 0, 0); clk_step();
        for (int c = 0; c < 7; c++) begin
            set_in(0, 0, 1); vectors++;
            if (dut_obs() !== mdl_obs()) begin miscompares++; $display("FAIL je_taken_run got=%h want=%h", dut_obs(), mdl_obs()); end
            clk_step();
        end
        vectors++;
        if (bus.pc !== 10'd32) begin miscompares++; $display("FAIL je_taken pc=%0d want=32", bus.pc); end
        for (int c = 0; c < 5; c++) begin set_in(0, 0, rb()); clk_step(); end
        rom[34] = filler();
        set_in(1, 0, 0); clk_step();
        for (int c = 0; c < 7; c++) begin
            set_in(0, 0, 0); vectors++;
            if (dut_obs() !== mdl_obs()) begin miscompares++; $display("FAIL je_not_taken_run got=%h want=%h", dut_obs(), mdl_obs()); end
            clk_step();
        end
        vectors++;
        if (bus.pc !== 10'd7) begin miscompares++; $display("FAIL je_not_taken pc=%0d want=7", bus.pc); end
        for (int c = 0; c < 39; c++) begin set_in(0, 0, rb()); clk_step(); end
        vectors++;
        if (bus.pc !== 10'd36) begin miscompares++; $display("FAIL j_back pc=%0d want=36", bus.pc); end
    endtask

    task automatic test_calls();
        int plan_n[4] = '{18, 4, 5, 5};
        int plan_pc[4] = '{36, 18, 60, 21};
        int plan_sp[4] = '{1, 0, 3, 0};
        restart(); fill_rom();
        rom[17] = 10'b1110_010011; rom[39] = 10'b0111_000000;
        rom[20] = 10'b1110_010100; rom[40] = 10'b1110_001010; rom[50] = 10'b1110_001010;
        rom[62] = 10'b0111_000000; rom[51] = 10'b0111_000000; rom[41] = 10'b0111_000000;
        rom[21] = 10'b1111_000000;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < plan_n[p]; c++) begin
                set_in(0, 0, rb()); vectors++;
                if (dut_obs() !== mdl_obs()) begin miscompares++; $display("FAIL calls p=%0d got=%h want=%h", p, dut_obs(), mdl_obs()); end
                clk_step();
            end
            vectors++;
            if (bus.pc !== 10'(plan_pc[p]) || bus.sp !== 3'(plan_sp[p])) begin
                miscompares++; $display("FAIL call_point p=%0d pc=%0d sp=%0d want %0d/%0d", p, bus.pc, bus.sp, plan_pc[p], plan_sp[p]);
            end
        end
        for (int c = 0; c < 2; c++) begin set_in(0, 0, 0); clk_step(); end
        vectors++;
        if (bus.halted !== 1'b1 || bus.stk_err !== 1'b0) begin miscompares++; $display("FAIL calls_end halted=%b err=%b want 1/0", bus.halted, bus.stk_err); end
    endtask

    task automatic test_overflow();
        restart(); fill_rom();
        rom[1] = 10'b1110_001001; rom[10] = 10'b1110_001010; rom[20] = 10'b1110_001010;
        rom[30] = 10'b1110_001010; rom[40] = 10'b1110_001010;
        for (int c = 0; c < 6; c++) begin
            set_in(0, 0, rb()); vectors++;
            if (dut_obs() !== mdl_obs()) begin miscompares++; $display("FAIL overflow_run got=%h want=%h", dut_obs(), mdl_obs()); end
            clk_step();
        end
        vectors++;
        if (bus.pc !== 10'd40 || bus.halted !== 1'b1 || bus.stk_err !== 1'b1 || bus.sp !== 3'd4) begin
            miscompares++; $display("FAIL overflow pc=%0d h=%b e=%b sp=%0d want 40/1/1/4", bus.pc, bus.halted, bus.stk_err, bus.sp);
        end
        rom[0] = 10'b0111_000000;
        set_in(1, 0, 0); clk_step();
        set_in(0, 0, 0); vectors++;
        if (bus.stk_err !== 1'b1 || bus.sp !== 3'd0 || bus.exec_en !== 1'b0) begin
            miscompares++; $display("FAIL sticky_err e=%b sp=%0d ex=%b want 1/0/0", bus.stk_err, bus.sp, bus.exec_en);
        end
        clk_step();
        vectors++;
        if (bus.pc !== 10'd0 || bus.halted !== 1'b1 || bus.stk_err !== 1'b1) begin
            miscompares++; $display("FAIL underflow pc=%0d h=%b e=%b want 0/1/1", bus.pc, bus.halted, bus.stk_err);
        end
    endtask

    task automatic test_stall();
        bit e;
        restart(); fill_rom();
        rom[3] = 10'b1101_011010; rom[29] = 10'b1111_000000;
        for (int c = 0; c < 3; c++) begin set_in(0, 0, 0); clk_step(); end
        for (int c = 0; c < 3; c++) begin
            set_in(0, 1, rb()); vectors++;
            if (dut_obs() !== mdl_obs() || bus.exec_en !== 1'b0) begin miscompares++; $display("FAIL stall_hold got=%h want=%h", dut_obs(), mdl_obs()); end
            clk_step();
        end
        vectors++;
        if (bus.pc !== 10'd3 || bus.halted !== 1'b0) begin miscompares++; $display("FAIL stall_pc pc=%0d want=3", bus.pc); end
        e = rb();
        set_in(0, 0, e); clk_step();
        vectors++;
        if (bus.pc !== (e ? 10'd29 : 10'd4)) begin miscompares++; $display("FAIL stall_release pc=%0d eq=%b", bus.pc, e); end
        for (int c = 0; c < 100 && m_mode == M_RUN; c++) begin
            set_in(0, $urandom_range(0, 9) < 3, rb()); vectors++;
            if (dut_obs() !== mdl_obs()) begin miscompares++; $display("FAIL stall_rand got=%h want=%h", dut_obs(), mdl_obs()); end
            clk_step();
        end
        vectors++;
        if (bus.halted !== 1'b1) begin miscompares++; $display("FAIL stall_budget halted=%b want=1", bus.halted); end
    endtask

    task automatic test_wrap();
        restart(); fill_rom();
        rom[0] = 10'b1100_111100; rom[1020] = 10'b1100_001010;
        rom[6] = 10'b1100_111100; rom[2] = 10'b1100_111100; rom[1023] = 10'b1111_000000;
        for (int c = 0; c < 6; c++) begin
            set_in(0, 0, rb()); vectors++;
            if (dut_obs() !== mdl_obs()) begin miscompares++; $display("FAIL wrap c=%0d got=%h want=%h", c, dut_obs(), mdl_obs()); end
            if (c == 2 && bus.pc !== 10'd6) begin miscompares++; $display("FAIL wrap_up pc=%0d want=6", bus.pc); end
            if (c == 4 && bus.pc !== 10'd1022) begin miscompares++; $display("FAIL wrap_down pc=%0d want=1022", bus.pc); end
            clk_step();
        end
        vectors += 2;
        rom[1023] = filler();
        set_in(1, 0, 0); clk_step();
        for (int c = 0; c < int'($urandom_range(7, 20)); c++) begin set_in(rb(), rb(), rb()); clk_step(); end
        rst = 1'b1; set_in(rb(), rb(), rb()); clk_step(); rst = 1'b0;
        set_in(0, 0, 0); vectors++;
        if (dut_obs() !== 16'h0000) begin miscompares++; $display("FAIL rst_mid got=%h want=0000", dut_obs()); end
        clk_step(); clk_step();
        set_in(1, 0, 0); clk_step();
        set_in(0, 0, 0); vectors++;
        if (bus.pc !== 10'd0 || bus.exec_en !== 1'b1) begin miscompares++; $display("FAIL resume pc=%0d ex=%b want 0/1", bus.pc, bus.exec_en); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] ctl [5] = '{10'b1100_000000, 10'b1101_000000, 10'b1110_000000, 10'b0111_000000, 10'b1111_000000};
        for (int a = 0; a < 1024; a++)
            rom[a] = ($urandom_range(0, 9) < 6) ? filler() : (ctl[$urandom_range(0, 4)] | 10'($urandom_range(0, 63)));
        restart();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, rb()); vectors++;
            if (dut_obs() !== mdl_obs()) begin miscompares++; $display("FAIL b2b c=%0d got=%h want=%h", c, dut_obs(), mdl_obs()); end
            clk_step();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.stall = 1'b0; bus.eq_flag = 1'b0;
        for (int a = 0; a < 1024; a++) rom[a] = 10'd0;
        @(negedge clk);
        test_reset();
        test_straight();
        test_branches();
        test_calls();
        test_overflow();
        test_stall();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
